// File: rtl/simple_tx.sv
// simple_tx: buffers one byte-stream frame, then serialises
// preamble, type, size, payload and additive FCS onto the line.
module simple_tx #(
  parameter int          G_MEM_SIZE = 100,
  parameter logic [15:0] G_TYPE     = 16'h1234,
  parameter int          G_MIN_SIZE = 8
) (
  input  logic        clk_in,
  input  logic        rst_n_in,
  input  logic [7:0]  tdata_in,
  input  logic        tvalid_in,
  input  logic        tlast_in,
  output logic        tready_out,
  output logic [7:0]  txd_out,
  output logic        txen_out,
  output logic        txer_out,
  output logic [15:0] stat_packet_sent_cnt,
  output logic [15:0] stat_packet_drop_cnt
);

  localparam int AW = $clog2(G_MEM_SIZE);
  localparam logic [7:0] MEM_SZ = 8'(G_MEM_SIZE);
  localparam logic [7:0] MIN_SZ = 8'(G_MIN_SIZE);

  localparam logic [2:0] S_FILL = 3'd0;
  localparam logic [2:0] S_PRE  = 3'd1;
  localparam logic [2:0] S_TYPE = 3'd2;
  localparam logic [2:0] S_SIZE = 3'd3;
  localparam logic [2:0] S_PAY  = 3'd4;
  localparam logic [2:0] S_FCS  = 3'd5;
  localparam logic [2:0] S_GAP  = 3'd6;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  psum_q, psum_d;
  logic        ovf_q, ovf_d;
  logic [15:0] sent_q, sent_d;
  logic [15:0] drop_q, drop_d;
  logic [7:0]  txd_q, txd_d;
  logic        txen_q, txen_d;
  logic        rdy_q, rdy_d;
  logic        acc, wr;

  logic [7:0] mem [G_MEM_SIZE];

  assign acc = tvalid_in && rdy_q && (state_q == S_FILL);
  assign wr  = acc && (cnt_q < MEM_SZ);

  always_ff @(posedge clk_in) begin
    if (wr) mem[cnt_q[AW-1:0]] <= tdata_in;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    psum_d  = psum_q;
    ovf_d   = ovf_q;
    sent_d  = sent_q;
    drop_d  = drop_q;
    unique case (state_q)
      S_FILL: begin
        if (acc) begin
          if (wr) begin
            cnt_d = cnt_q + 8'd1;
            if (cnt_q < 8'd4) psum_d = psum_q + tdata_in;
          end else begin
            ovf_d = 1'b1;
          end
          if (tlast_in) begin
            if (!ovf_q && wr && (cnt_q + 8'd1 >= MIN_SZ)) begin
              state_d = S_PRE;
              idx_d   = 8'd0;
            end else begin
              drop_d = drop_q + 16'd1;
              cnt_d  = 8'd0;
              ovf_d  = 1'b0;
              psum_d = 8'd0;
            end
          end
        end
      end
      // idx 0 is a silent launch cycle; idx 1..4 carry the preamble
      S_PRE: begin
        if (idx_q == 8'd4) begin
          state_d = S_TYPE;
          idx_d   = 8'd0;
        end else begin
          idx_d = idx_q + 8'd1;
        end
      end
      S_TYPE: begin
        if (idx_q == 8'd1) state_d = S_SIZE;
        else idx_d = idx_q + 8'd1;
      end
      S_SIZE: begin
        state_d = S_PAY;
        idx_d   = 8'd0;
      end
      S_PAY: begin
        if (idx_q == cnt_q - 8'd1) state_d = S_FCS;
        else idx_d = idx_q + 8'd1;
      end
      S_FCS: state_d = S_GAP;
      S_GAP: begin
        state_d = S_FILL;
        sent_d  = sent_q + 16'd1;
        cnt_d   = 8'd0;
        ovf_d   = 1'b0;
        psum_d  = 8'd0;
      end
      default: state_d = S_FILL;
    endcase
  end

  // line registers are decoded from the next state so they align with it
  always_comb begin
    txen_d = 1'b0;
    txd_d  = 8'h00;
    rdy_d  = (state_d == S_FILL);
    unique case (state_d)
      S_PRE: begin
        if (idx_d != 8'd0) begin
          txen_d = 1'b1;
          txd_d  = (idx_d == 8'd4) ? 8'h7F : 8'h55;
        end
      end
      S_TYPE: begin
        txen_d = 1'b1;
        txd_d  = (idx_d == 8'd0) ? G_TYPE[15:8] : G_TYPE[7:0];
      end
      S_SIZE: begin
        txen_d = 1'b1;
        txd_d  = cnt_d;
      end
      S_PAY: begin
        txen_d = 1'b1;
        txd_d  = mem[idx_d[AW-1:0]];
      end
      S_FCS: begin
        txen_d = 1'b1;
        txd_d  = G_TYPE[15:8] + G_TYPE[7:0] + cnt_q + psum_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= S_FILL;
      cnt_q   <= 8'd0;
      idx_q   <= 8'd0;
      psum_q  <= 8'd0;
      ovf_q   <= 1'b0;
      sent_q  <= 16'd0;
      drop_q  <= 16'd0;
      txd_q   <= 8'h00;
      txen_q  <= 1'b0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      psum_q  <= psum_d;
      ovf_q   <= ovf_d;
      sent_q  <= sent_d;
      drop_q  <= drop_d;
      txd_q   <= txd_d;
      txen_q  <= txen_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tready_out           = rdy_q;
  assign txd_out              = txd_q;
  assign txen_out             = txen_q;
  assign txer_out             = 1'b0;
  assign stat_packet_sent_cnt = sent_q;
  assign stat_packet_drop_cnt = drop_q;

endmodule

// File: tb/tb_simple_tx.sv
// tb_simple_tx: table-driven and random frames checked against
// a frame-level model of the transmitted line sequence.
module tb_simple_tx;

  typedef logic [7:0] bq_t[$];

  typedef struct {
    int         len;
    logic [7:0] first;
    logic [7:0] step;
    int         gap;
    logic [7:0] fcs;
    int         on;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  tdata = 8'h00;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic        tready;
  logic [7:0]  txd;
  logic        txen;
  logic        txer;
  logic [15:0] sent_cnt;
  logic [15:0] drop_cnt;

  int   nvec = 0;
  int   nerr = 0;
  int   rises = 0;
  logic prev_txen = 1'b0;
  bq_t  lineq;
  int   exp_sent = 0;
  int   exp_drop = 0;

  simple_tx dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .tdata_in(tdata),
    .tvalid_in(tvalid),
    .tlast_in(tlast),
    .tready_out(tready),
    .txd_out(txd),
    .txen_out(txen),
    .txer_out(txer),
    .stat_packet_sent_cnt(sent_cnt),
    .stat_packet_drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("txer", 32'(txer), 0);
      if (txen) lineq.push_back(txd);
      else chk("idle_txd", 32'(txd), 0);
      if (txen || prev_txen) chk("tready_tx", 32'(tready), 0);
      if (txen && !prev_txen) rises++;
      prev_txen <= txen;
    end else begin
      prev_txen <= 1'b0;
    end
  end

  function automatic bq_t model(input bq_t d);
    bq_t        q;
    logic [7:0] s;
    q = '{8'h55, 8'h55, 8'h55, 8'h7F, 8'h12, 8'h34};
    q.push_back(8'(d.size()));
    s = 8'h12 + 8'h34 + 8'(d.size());
    foreach (d[i]) begin
      q.push_back(d[i]);
      if (i < 4) s = s + d[i];
    end
    q.push_back(s);
    return q;
  endfunction

  task automatic send(input bq_t d, input int gap);
    int t;
    for (int i = 0; i < d.size(); i++) begin
      while (gap > 0 && $urandom_range(99) < gap) begin
        tvalid = 1'b0;
        @(negedge clk);
      end
      tvalid = 1'b1;
      tdata  = d[i];
      tlast  = (i == d.size() - 1);
      t = 0;
      while (!tready && t < 300) begin
        @(negedge clk);
        t++;
      end
      if (t == 300) chk("tready_timeout", 32'(tready), 1);
      @(negedge clk);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic run_frame(input bq_t d, input int gap,
                           input logic [7:0] fcs, input int on);
    bq_t exp;
    int  r0, t;
    bit  ok;
    ok = (d.size() >= 8) && (d.size() <= 100);
    lineq.delete();
    r0 = rises;
    send(d, gap);
    if (ok) begin
      t = 0;
      while (!(rises > r0 && !txen) && t < 2000) begin
        @(negedge clk);
        t++;
      end
      if (t == 2000) chk("frame_timeout", 32'(t), 0);
      @(negedge clk);
      exp_sent++;
    end else begin
      repeat (20) @(negedge clk);
      exp_drop++;
    end
    chk("line_len", 32'(lineq.size()), ok ? 32'(d.size() + 8) : 0);
    if (on >= 0) chk("txen_cycles", 32'(lineq.size()), 32'(on));
    chk("bursts", 32'(rises - r0), ok ? 1 : 0);
    if (ok && lineq.size() == d.size() + 8) begin
      exp = model(d);
      foreach (exp[i]) chk($sformatf("byte%0d", i), 32'(lineq[i]),
                           32'(exp[i]));
      if (on >= 0) chk("fcs", 32'(lineq[lineq.size()-1]), 32'(fcs));
    end
    chk("sent_cnt", 32'(sent_cnt), 32'(exp_sent));
    chk("drop_cnt", 32'(drop_cnt), 32'(exp_drop));
    chk("tready_fill", 32'(tready), 1);
  endtask

  function automatic bq_t mk(input int len, input logic [7:0] first,
                             input logic [7:0] step);
    bq_t q;
    for (int i = 0; i < len; i++) q.push_back(8'(first + 8'(i) * step));
    return q;
  endfunction

  vec_t tbl[8];
  bq_t  d;
  int   t;

  initial begin
    tbl[0] = '{10,  8'h11, 8'h11, 0,  8'hFA, 18};
    tbl[1] = '{3,   8'h01, 8'h01, 0,  8'h00, 0};
    tbl[2] = '{8,   8'h01, 8'h01, 0,  8'h58, 16};
    tbl[3] = '{100, 8'h00, 8'h01, 0,  8'hB0, 108};
    tbl[4] = '{101, 8'h00, 8'h01, 0,  8'h00, 0};
    tbl[5] = '{7,   8'h01, 8'h01, 0,  8'h00, 0};
    tbl[6] = '{12,  8'h10, 8'h03, 40, 8'hA4, 20};
    tbl[7] = '{8,   8'hFF, 8'h00, 0,  8'h4A, 16};

    #12;
    chk("rst_tready", 32'(tready), 0);
    chk("rst_txen", 32'(txen), 0);
    chk("rst_txd", 32'(txd), 0);
    chk("rst_sent", 32'(sent_cnt), 0);
    chk("rst_drop", 32'(drop_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_after_rst", 32'(tready), 1);

    foreach (tbl[k]) begin
      d = mk(tbl[k].len, tbl[k].first, tbl[k].step);
      run_frame(d, tbl[k].gap, tbl[k].fcs, tbl[k].on);
    end
    d = mk(12, 8'h10, 8'h03);
    run_frame(d, 0, 8'hA4, 20);

    for (int r = 0; r < 8; r++) begin
      d.delete();
      for (int i = 0; i < $urandom_range(110, 1); i++)
        d.push_back(8'($urandom));
      run_frame(d, $urandom_range(40), 8'h00, -1);
    end

    lineq.delete();
    d = mk(40, 8'h20, 8'h01);
    send(d, 0);
    t = 0;
    while (lineq.size() < 10 && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("reach_payload", 32'(lineq.size() >= 10), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_txen", 32'(txen), 0);
    chk("mid_rst_txd", 32'(txd), 0);
    chk("mid_rst_tready", 32'(tready), 0);
    chk("mid_rst_sent", 32'(sent_cnt), 0);
    chk("mid_rst_drop", 32'(drop_cnt), 0);
    exp_sent = 0;
    exp_drop = 0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("tready_rel", 32'(tready), 1);
    chk("txen_rel", 32'(txen), 0);
    d = mk(9, 8'hF0, 8'h10);
    run_frame(d, 0, 8'h6F, 17);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
